// File: rtl/stg_mo_hs_if.sv
// rtl/stg_mo_hs_if.sv - multi-port memory request/ack bus used by the memory-op stage
interface stg_mo_hs_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 24,
  parameter int NPORT  = 2
);
  logic [NPORT-1:0]        ow_mem_req;
  logic                    ow_mem_we;
  logic [ADDR_W-1:0]       ow_mem_addr;
  logic [DATA_W-1:0]       ow_mem_wdata;
  logic [NPORT-1:0]        iw_mem_ack;
  logic [NPORT*DATA_W-1:0] iw_mem_rdata;

  modport master (
    output ow_mem_req, ow_mem_we, ow_mem_addr, ow_mem_wdata,
    input  iw_mem_ack, iw_mem_rdata
  );

  modport slave (
    input  ow_mem_req, ow_mem_we, ow_mem_addr, ow_mem_wdata,
    output iw_mem_ack, iw_mem_rdata
  );
endinterface

// File: rtl/stg_mo_hs.sv
// rtl/stg_mo_hs.sv - memory-op pipeline stage: holds one load/store on a selected port until ack or timeout
module stg_mo_hs #(
  parameter int  DATA_W  = 24,
  parameter int  ADDR_W  = 24,
  parameter int  NPORT   = 2,
  parameter int  TGT_W   = 4,
  parameter int  TIMEOUT = 15,
  localparam int MP_W    = $clog2(NPORT)
) (
  input  logic              iw_clk,
  input  logic              iw_rst_n,
  input  logic              iw_valid,
  input  logic [ADDR_W-1:0] iw_pc,
  input  logic [DATA_W-1:0] iw_instr,
  input  logic [TGT_W-1:0]  iw_tgt_gp,
  input  logic              iw_tgt_gp_we,
  input  logic [1:0]        iw_mem_op,
  input  logic [MP_W-1:0]   iw_mem_mp,
  input  logic [ADDR_W-1:0] iw_addr,
  input  logic [DATA_W-1:0] iw_result,
  output logic              ow_stall,
  stg_mo_hs_if.master       mem,
  output logic              ow_valid,
  output logic [ADDR_W-1:0] ow_pc,
  output logic [DATA_W-1:0] ow_instr,
  output logic [TGT_W-1:0]  ow_tgt_gp,
  output logic              ow_tgt_gp_we,
  output logic [DATA_W-1:0] ow_result,
  output logic              ow_fault
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [7:0]        cnt;
  logic              cap_store;
  logic [MP_W-1:0]   cap_mp;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [ADDR_W-1:0] cap_pc;
  logic [DATA_W-1:0] cap_instr;
  logic [TGT_W-1:0]  cap_tgt;
  logic              cap_tgt_we;

  logic              is_mem;
  logic              ack_hit;
  logic [DATA_W-1:0] rdata_sel;
  logic              do_pass, do_start, do_ack, do_timeout;
  logic [NPORT-1:0]  req_vec;

  assign is_mem = (iw_mem_op == 2'b01) || (iw_mem_op == 2'b10);

  // Only the captured port's ack/rdata matter; every other port is ignored.
  always_comb begin
    ack_hit   = 1'b0;
    rdata_sel = '0;
    req_vec   = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (cap_mp == MP_W'(p)) begin
        ack_hit    = mem.iw_mem_ack[p];
        rdata_sel  = mem.iw_mem_rdata[p*DATA_W +: DATA_W];
        req_vec[p] = (state == ST_BUSY);
      end
    end
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_pass    = 1'b0;
    do_start   = 1'b0;
    do_ack     = 1'b0;
    do_timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (iw_valid) begin
          if (is_mem) begin
            do_start  = 1'b1;
            state_nxt = ST_BUSY;
          end else begin
            do_pass = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (ack_hit) begin
          do_ack    = 1'b1;
          state_nxt = ST_IDLE;
        end else if (cnt == TO_LAST) begin
          do_timeout = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus outputs come straight from state so reset drops them without waiting for a clock.
  assign ow_stall         = (state == ST_BUSY);
  assign mem.ow_mem_req   = req_vec;
  assign mem.ow_mem_we    = (state == ST_BUSY) && cap_store;
  assign mem.ow_mem_addr  = (state == ST_BUSY) ? cap_addr  : '0;
  assign mem.ow_mem_wdata = (state == ST_BUSY) ? cap_wdata : '0;

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      cnt          <= '0;
      cap_store    <= 1'b0;
      cap_mp       <= '0;
      cap_addr     <= '0;
      cap_wdata    <= '0;
      cap_pc       <= '0;
      cap_instr    <= '0;
      cap_tgt      <= '0;
      cap_tgt_we   <= 1'b0;
      ow_valid     <= 1'b0;
      ow_pc        <= '0;
      ow_instr     <= '0;
      ow_tgt_gp    <= '0;
      ow_tgt_gp_we <= 1'b0;
      ow_result    <= '0;
      ow_fault     <= 1'b0;
    end else begin
      ow_valid <= 1'b0;
      if (do_pass) begin
        ow_valid     <= 1'b1;
        ow_pc        <= iw_pc;
        ow_instr     <= iw_instr;
        ow_tgt_gp    <= iw_tgt_gp;
        ow_tgt_gp_we <= iw_tgt_gp_we;
        ow_result    <= iw_result;
        ow_fault     <= 1'b0;
      end
      if (do_start) begin
        cnt        <= '0;
        cap_store  <= (iw_mem_op == 2'b10);
        cap_mp     <= iw_mem_mp;
        cap_addr   <= iw_addr;
        cap_wdata  <= iw_result;
        cap_pc     <= iw_pc;
        cap_instr  <= iw_instr;
        cap_tgt    <= iw_tgt_gp;
        cap_tgt_we <= iw_tgt_gp_we;
      end
      if (state == ST_BUSY && !do_ack && !do_timeout) begin
        cnt <= cnt + 8'd1;
      end
      if (do_ack || do_timeout) begin
        ow_valid     <= 1'b1;
        ow_pc        <= cap_pc;
        ow_instr     <= cap_instr;
        ow_tgt_gp    <= cap_tgt;
        ow_tgt_gp_we <= do_ack ? cap_tgt_we : 1'b0;
        ow_fault     <= do_timeout;
        if (do_timeout)     ow_result <= '0;
        else if (cap_store) ow_result <= cap_wdata;
        else                ow_result <= rdata_sel;
      end
    end
  end

endmodule
